// File: rtl/seq_player_if.sv
// rtl/seq_player_if.sv - playback request and lamp/status bundle for seq_player
// Optional abort signal exists only when PLAYER_ABORT_EN is defined.
interface seq_player_if;
  logic        start;
  logic [3:0]  level;
  logic [63:0] seq;
`ifdef PLAYER_ABORT_EN
  logic        abort;
`endif
  logic [3:0]  led;
  logic        busy;
  logic        done;

`ifdef PLAYER_ABORT_EN
  modport master (output start, level, seq, abort, input led, busy, done);
  modport slave  (input start, level, seq, abort, output led, busy, done);
`else
  modport master (output start, level, seq, input led, busy, done);
  modport slave  (input start, level, seq, output led, busy, done);
`endif
endinterface

// File: rtl/seq_player.sv
// rtl/seq_player.sv - plays back latched colour steps with lit/dark timing
// Optional feature macro: PLAYER_ABORT_EN (adds abort of an in-progress playback).
module seq_player #(
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned OFF_CYCLES = 12500000
) (
  input logic         CLK,
  input logic         R,
  seq_player_if.slave p
);

  typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;

  localparam logic [31:0] ON_LOAD  = 32'(ON_CYCLES - 1);
  localparam logic [31:0] OFF_LOAD = 32'(OFF_CYCLES - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [3:0]  step;
  logic [3:0]  lvl_q;
  logic [63:0] seq_q;
  logic [3:0]  step_nx;
  logic [3:0]  led_r;
  logic        busy_r;
  logic        done_r;

  // Only evaluated when step < lvl_q, so it can never wrap past 15.
  assign step_nx = step + 4'd1;

  assign p.led  = led_r;
  assign p.busy = busy_r;
  assign p.done = done_r;

  always_ff @(posedge CLK) begin
    if (R) begin
      state  <= IDLE;
      cnt    <= '0;
      step   <= '0;
      lvl_q  <= '0;
      seq_q  <= '0;
      led_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
`ifdef PLAYER_ABORT_EN
      if (p.abort && (state == ON || state == OFF)) begin
        state  <= IDLE;
        cnt    <= '0;
        step   <= '0;
        led_r  <= '0;
        busy_r <= 1'b0;
      end else
`endif
      case (state)
        IDLE: begin
          if (p.start) begin
            seq_q  <= p.seq;
            lvl_q  <= p.level;
            step   <= '0;
            cnt    <= ON_LOAD;
            led_r  <= p.seq[3:0];
            busy_r <= 1'b1;
            state  <= ON;
          end
        end
        ON: begin
          if (cnt == '0) begin
            cnt   <= OFF_LOAD;
            led_r <= '0;
            state <= OFF;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        OFF: begin
          if (cnt != '0) begin
            cnt <= cnt - 32'd1;
          end else if (step < lvl_q) begin
            step  <= step_nx;
            cnt   <= ON_LOAD;
            led_r <= seq_q[{step_nx, 2'b00} +: 4];
            state <= ON;
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
